// File: rtl/traffic_light_fsm.sv
// traffic_light_fsm
//   Two-road intersection sequencer (north-south / east-west) stepped by a
//   one-cycle tick from an upstream counter. Each phase lasts a whole number
//   of ticks. Light outputs are a Moore decode of the registered state.
//
//   Optional feature macro: TRAFFIC_PED_REQ_EN
//     defined   -> pedestrian latch, WALK state and the EW_YELLOW->WALK branch
//     undefined -> ped_req unused, walk/ped_pending tied low, code 6 illegal
//
// Ports
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   tick         in   one-cycle phase-advance enable
//   ped_req      in   pedestrian button (level)
//   ns_light     out  north-south lights {red,yellow,green}
//   ew_light     out  east-west lights {red,yellow,green}
//   walk         out  walk lamp
//   ped_pending  out  latched pedestrian request
//   state        out  current state code (debug / LEDs)
//
// Handshake: there is no valid/ready pair here; tick is a plain enable that
// is acted on in every cycle it is high, with no back-pressure.

module traffic_light_fsm #(
  parameter int GREEN_TICKS  = 8,
  parameter int YELLOW_TICKS = 2,
  parameter int ALLRED_TICKS = 1,
  parameter int WALK_TICKS   = 4,
  parameter int CNT_WIDTH    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       ped_req,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] state
);

  localparam logic [2:0] NS_GREEN  = 3'd0;
  localparam logic [2:0] NS_YELLOW = 3'd1;
  localparam logic [2:0] ALL_RED_A = 3'd2;
  localparam logic [2:0] EW_GREEN  = 3'd3;
  localparam logic [2:0] EW_YELLOW = 3'd4;
  localparam logic [2:0] ALL_RED_B = 3'd5;
  localparam logic [2:0] WALK      = 3'd6;

  localparam logic [2:0] L_RED    = 3'b100;
  localparam logic [2:0] L_YELLOW = 3'b010;
  localparam logic [2:0] L_GREEN  = 3'b001;

  // A dwell of 0 behaves as 1 tick.
  localparam int G_DUR = (GREEN_TICKS  < 1) ? 1 : GREEN_TICKS;
  localparam int Y_DUR = (YELLOW_TICKS < 1) ? 1 : YELLOW_TICKS;
  localparam int A_DUR = (ALLRED_TICKS < 1) ? 1 : ALLRED_TICKS;
  localparam int W_DUR = (WALK_TICKS   < 1) ? 1 : WALK_TICKS;

  // Terminal dwell values (DUR-1 always fits because DUR <= 2^CNT_WIDTH).
  localparam logic [CNT_WIDTH-1:0] G_LAST = CNT_WIDTH'(G_DUR - 1);
  localparam logic [CNT_WIDTH-1:0] Y_LAST = CNT_WIDTH'(Y_DUR - 1);
  localparam logic [CNT_WIDTH-1:0] A_LAST = CNT_WIDTH'(A_DUR - 1);
  localparam logic [CNT_WIDTH-1:0] W_LAST = CNT_WIDTH'(W_DUR - 1);
  localparam logic [CNT_WIDTH-1:0] ONE    = CNT_WIDTH'(1);

  logic [2:0]           state_q;
  logic [CNT_WIDTH-1:0] dwell_q;
  logic                 ped_q;

  logic                 state_legal;
  logic [CNT_WIDTH-1:0] dur_last;
  logic [2:0]           seq_next;
  logic                 phase_done;

  // Per-state terminal dwell and successor.
  always_comb begin
    state_legal = 1'b1;
    dur_last    = A_LAST;
    seq_next    = ALL_RED_B;
    case (state_q)
      NS_GREEN:  begin dur_last = G_LAST; seq_next = NS_YELLOW; end
      NS_YELLOW: begin dur_last = Y_LAST; seq_next = ALL_RED_A; end
      ALL_RED_A: begin dur_last = A_LAST; seq_next = EW_GREEN;  end
      EW_GREEN:  begin dur_last = G_LAST; seq_next = EW_YELLOW; end
      EW_YELLOW: begin
        dur_last = Y_LAST;
        // Pedestrian phase is inserted only when a request was already latched.
        seq_next = ped_q ? WALK : ALL_RED_B;
      end
      ALL_RED_B: begin dur_last = A_LAST; seq_next = NS_GREEN;  end
`ifdef TRAFFIC_PED_REQ_EN
      WALK:      begin dur_last = W_LAST; seq_next = ALL_RED_B; end
`endif
      default:   state_legal = 1'b0;
    endcase
  end

  assign phase_done = state_legal && tick && (dwell_q == dur_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ALL_RED_B;
      dwell_q <= '0;
    end else if (!state_legal) begin
      // Unreachable codes fall back to the safe all-red phase.
      state_q <= ALL_RED_B;
      dwell_q <= '0;
    end else if (tick) begin
      if (phase_done) begin
        state_q <= seq_next;
        dwell_q <= '0;
      end else begin
        dwell_q <= dwell_q + ONE;
      end
    end
  end

`ifdef TRAFFIC_PED_REQ_EN
  logic enter_walk;
  assign enter_walk = phase_done && (seq_next == WALK);

  // Clear on WALK entry wins over a simultaneous set; presses during WALK
  // are dropped so one request yields one walk phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      ped_q <= 1'b0;
    end else if (enter_walk) begin
      ped_q <= 1'b0;
    end else if (ped_req && (state_q != WALK)) begin
      ped_q <= 1'b1;
    end
  end

  assign ped_pending = ped_q;
`else
  logic unused_ped_req;
  assign unused_ped_req = ped_req;
  assign ped_q          = 1'b0;
  assign ped_pending    = 1'b0;
`endif

  // Moore decode; anything not explicitly a go phase shows red both ways.
  always_comb begin
    ns_light = L_RED;
    ew_light = L_RED;
    walk     = 1'b0;
    case (state_q)
      NS_GREEN:  ns_light = L_GREEN;
      NS_YELLOW: ns_light = L_YELLOW;
      EW_GREEN:  ew_light = L_GREEN;
      EW_YELLOW: ew_light = L_YELLOW;
`ifdef TRAFFIC_PED_REQ_EN
      WALK:      walk = 1'b1;
`endif
      default: begin
        ns_light = L_RED;
        ew_light = L_RED;
      end
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Testbench for traffic_light_fsm: reference model drives an expected queue,
// DUT outputs are popped and compared one clock later.

module tb_traffic_light_fsm;

  logic       clk = 1'b0;
  logic       reset, tick, ped_req;
  logic [2:0] ns_light, ew_light, state;
  logic       walk, ped_pending;

  traffic_light_fsm dut (
    .clk(clk), .reset(reset), .tick(tick), .ped_req(ped_req),
    .ns_light(ns_light), .ew_light(ew_light), .walk(walk),
    .ped_pending(ped_pending), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // {state[2:0], ns[2:0], ew[2:0], walk, ped_pending}
  logic [10:0] exp_q[$];

  // reference model
  int m_st = 5, m_dw = 0;
  logic m_pend = 1'b0;

  // period measurement between NS_GREEN entries
  int   cyc = 0, last_entry = -1, exp_period = 0;
  bit   measure_en = 0;
  logic [2:0] prev_st = 3'd5;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int dur_of(input int s);
    case (s)
      0, 3:    return 8;
      1, 4:    return 2;
      6:       return 4;
      default: return 1;
    endcase
  endfunction

  function automatic logic [6:0] lights_of(input int s);
    // {ns, ew, walk}
    case (s)
      0:       return {3'b001, 3'b100, 1'b0};
      1:       return {3'b010, 3'b100, 1'b0};
      3:       return {3'b100, 3'b001, 1'b0};
      4:       return {3'b100, 3'b010, 1'b0};
      6:       return {3'b100, 3'b100, 1'b1};
      default: return {3'b100, 3'b100, 1'b0};
    endcase
  endfunction

  task automatic model_step(input logic rst, input logic tk, input logic pr);
    bit legal, done;
    int nxt;
    if (rst) begin
      m_st = 5; m_dw = 0; m_pend = 1'b0;
      return;
    end
`ifdef TRAFFIC_PED_REQ_EN
    legal = (m_st <= 6);
`else
    legal = (m_st <= 5);
`endif
    done = legal && tk && (m_dw + 1 >= dur_of(m_st));
    case (m_st)
      0: nxt = 1;  1: nxt = 2;  2: nxt = 3;  3: nxt = 4;
      4: nxt = m_pend ? 6 : 5;
      5: nxt = 0;
      default: nxt = 5;
    endcase
`ifdef TRAFFIC_PED_REQ_EN
    if (done && nxt == 6)          m_pend = 1'b0;
    else if (pr && m_st != 6)      m_pend = 1'b1;
`endif
    if (!legal) begin
      m_st = 5; m_dw = 0;
    end else if (done) begin
      m_st = nxt; m_dw = 0;
    end else if (tk) begin
      m_dw = m_dw + 1;
    end
  endtask

  // One clock: drive at negedge, predict, compare #1 after the rising edge.
  task automatic drive_cycle(input logic rst, input logic tk, input logic pr);
    logic [10:0] e;
    @(negedge clk);
    reset = rst; tick = tk; ped_req = pr;
    model_step(rst, tk, pr);
    exp_q.push_back({m_st[2:0], lights_of(m_st), m_pend});
    @(posedge clk);
    #1;
    cyc++;
    e = exp_q.pop_front();
    check("state", 32'(state), 32'(e[10:8]));
    check("ns_light", 32'(ns_light), 32'(e[7:5]));
    check("ew_light", 32'(ew_light), 32'(e[4:2]));
    check("walk", 32'(walk), 32'(e[1]));
    check("ped_pending", 32'(ped_pending), 32'(e[0]));
    check("safety", 32'((ns_light != 3'b100) && (ew_light != 3'b100)), 32'd0);
    if (state == 3'd0 && prev_st != 3'd0) begin
      if (measure_en && last_entry >= 0) check("period", 32'(cyc - last_entry), 32'(exp_period));
      last_entry = cyc;
    end
    prev_st = state;
  endtask

  task automatic start_section(input bit en, input int period);
    measure_en = en; exp_period = period; last_entry = -1;
    drive_cycle(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; ped_req = 1'b0;

    // reset state
    start_section(1'b1, 22);
    check("reset_dwell", 32'(dut.dwell_q), 32'd0);

    // continuous ticks: 22-clock cycle
    for (int i = 0; i < 70; i++) drive_cycle(1'b0, 1'b1, 1'b0);

    // tick every third clock: every phase stretched x3
    start_section(1'b1, 66);
    for (int i = 0; i < 200; i++) drive_cycle(1'b0, (i % 3) == 0, 1'b0);

`ifdef TRAFFIC_PED_REQ_EN
    // one pedestrian press during NS_GREEN
    start_section(1'b0, 0);
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1, 1'b0);
    drive_cycle(1'b0, 1'b1, 1'b1);
    check("ped_latched", 32'(ped_pending), 32'd1);
    for (int i = 0; i < 50; i++) drive_cycle(1'b0, 1'b1, 1'b0);

    // request held through WALK: re-arms after exit
    start_section(1'b0, 0);
    for (int i = 0; i < 80; i++) drive_cycle(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 30; i++) drive_cycle(1'b0, 1'b1, 1'b0);
`endif

    // reset in the middle of EW_GREEN with dwell 4
    start_section(1'b0, 0);
    begin
      int n = 0;
      while (!(m_st == 3 && m_dw == 4) && n < 100) begin
        drive_cycle(1'b0, 1'b1, 1'b0);
        n++;
      end
      check("reach_ew_green_dwell4", 32'(n < 100), 32'd1);
    end
    drive_cycle(1'b1, 1'b1, 1'b0);
    check("midreset_dwell", 32'(dut.dwell_q), 32'd0);

    // illegal code recovery
    for (int i = 0; i < 5; i++) drive_cycle(1'b0, 1'b1, 1'b0);
    force dut.state_q = 3'd7;
    #1;
    release dut.state_q;
    #1;
    check("forced_state", 32'(state), 32'd7);
    m_st = 7;
    drive_cycle(1'b0, 1'b1, 1'b0);
    check("recover_dwell", 32'(dut.dwell_q), 32'd0);

    // random tick / ped_req soak
    start_section(1'b0, 0);
    for (int i = 0; i < 1000; i++)
      drive_cycle(1'b0, $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_light_fsm.md
# traffic_light_fsm

Downstream consumer of the tick counter's `flag` pulse. Sequences a two-road intersection (north-south / east-west) through green, yellow and all-red phases, with each phase lasting a whole number of ticks. Drives the Basys3 light outputs directly. An optional pedestrian phase is compiled in with a macro.

## Interface
- `GREEN_TICKS`, default 8: dwell of each green phase, in ticks.
- `YELLOW_TICKS`, default 2: dwell of each yellow phase, in ticks.
- `ALLRED_TICKS`, default 1: dwell of each all-red phase, in ticks.
- `WALK_TICKS`, default 4: dwell of the walk phase (only with `PED_REQ_EN`).
- `CNT_WIDTH`, default 8: dwell counter width. Every dwell value must be ≤ 2^CNT_WIDTH.
- `clk` input 1: system clock.
- `reset` input 1: synchronous, active-high reset.
- `tick` input 1: one-cycle enable from the upstream counter `flag`. Each high cycle counts as one tick.
- `ped_req` input 1: pedestrian button, level. Ignored without `PED_REQ_EN`.
- `ns_light` output 3: north-south lights, {red,yellow,green}.
- `ew_light` output 3: east-west lights, {red,yellow,green}.
- `walk` output 1: walk lamp.
- `ped_pending` output 1: latched pedestrian request.
- `state` output 3: current state code, for debug and LEDs.

## Operation
- States and codes: NS_GREEN=0, NS_YELLOW=1, ALL_RED_A=2, EW_GREEN=3, EW_YELLOW=4, ALL_RED_B=5, WALK=6.
- Sequence: NS_GREEN→NS_YELLOW→ALL_RED_A→EW_GREEN→EW_YELLOW→ALL_RED_B→NS_GREEN.
- With a pending request, EW_YELLOW→WALK→ALL_RED_B instead of EW_YELLOW→ALL_RED_B.
- Dwell counter `dwell` (CNT_WIDTH bits):
  - On a cycle with `tick`=1 and `dwell`==DUR−1: transition to the next state and clear `dwell` to 0.
  - On any other cycle with `tick`=1: increment `dwell`.
  - On cycles with `tick`=0: hold `dwell`.
- A dwell parameter of 0 is treated as 1.
- Outputs are a Moore decode of the registered state:
  - Green states: that road = 001, other road = 100.
  - Yellow states: that road = 010, other road = 100.
  - ALL_RED_A, ALL_RED_B, WALK: both roads = 100.
  - `walk`=1 only in WALK.
- No state may ever drive green or yellow on both roads at once.
- Illegal state codes (7) recover to ALL_RED_B on the next clock, with `dwell` cleared.
- Pedestrian latch:
  - Set when `ped_req`=1 in any state other than WALK.
  - Cleared on the clock that enters WALK. Clear wins if set and clear coincide.
  - Requests asserted during WALK are dropped.

## Timing
- Reset is synchronous: it takes effect on the `clk` edge where `reset`=1.
- Reset values:
  - `state`=ALL_RED_B (5), `dwell`=0.
  - `ns_light`=100, `ew_light`=100.
  - `walk`=0, `ped_pending`=0.
- Reset asserted mid-phase aborts immediately to the reset values, with no yellow transition. Reset has priority over `tick`.
- State and outputs update on the same edge that samples the terminal tick. Light change latency from the terminal `tick` is 1 clock.
- `ped_pending` rises 1 clock after `ped_req` is sampled high.
- Phase lengths, with `tick` every cycle and default parameters:
  - Full cycle without walk: 22 clocks.
  - Full cycle with walk: 26 clocks.
- Phase lengths with a tick every N clocks: dwell × N clocks.

## Configuration
- Macro: `TRAFFIC_PED_REQ_EN`.
- Defined: the pedestrian latch, the WALK state and the WALK branch are present, and `walk` / `ped_pending` are live.
- Undefined:
  - `ped_req` is unused.
  - `walk` and `ped_pending` are tied to 0.
  - State 6 is illegal and recovers like 7.
  - The cycle is always 22 ticks.

## Test plan
- Reset, then `tick`=1 continuously → 1 clock of all-red, then NS `001`/EW `100` for 8 clocks, `010` for 2, all-red for 1, then EW green for 8. Sequence repeats every 22 clocks.
- `tick` pulsed once every 3 clocks → every phase lasts exactly 3× its dwell. Lights hold during the gaps where `tick`=0.
- With the macro defined, pulse `ped_req` during NS_GREEN:
  - `ped_pending`=1 on the next clock.
  - After EW_YELLOW: WALK with `walk`=1 for 4 ticks.
  - Then ALL_RED_B, with `ped_pending`=0.
- `ped_req` held high through WALK → no second walk phase in that cycle. The latch re-arms on the first cycle after WALK exit, producing a walk phase in the next cycle.
- Assert `reset` for 1 clock in the middle of EW_GREEN (`dwell`=4) → next clock shows `state`=5, both roads `100`, `dwell`=0.
- Force `state`=7 → recovers to ALL_RED_B on the next clock. Across a 1000-clock random `tick`/`ped_req` run, no cycle shows both roads non-red.
